// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit hex display driver with a double-buffered value,
// optional leading-zero blanking and registered active-low outputs.
module hex_display_scanner #(
  parameter int DIV_COUNT    = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        BLANK_EN,
  input  logic        LOAD,
  input  logic [15:0] DATA_IN,
  output logic        LOAD_ACK,
  output logic        PENDING,
  output logic        FRAME_DONE,
  output logic [3:0]  DIGIT_SEL_N,
  output logic [6:0]  SEG_N
);

  typedef enum logic [1:0] {S_OFF, S_SHOW, S_GUARD} state_t;

  localparam logic [15:0] SHOW_LAST  = 16'(DIV_COUNT - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic        ack_q, ack_d;
  logic        frame_q, frame_d;
  logic [3:0]  sel_n_q, sel_n_d;
  logic [6:0]  seg_n_q, seg_n_d;
  logic        commit_c;
  logic [3:0]  nib_c;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
    endcase
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
    case (idx)
      2'd1:    leading_zero = (v[15:4] == 12'h000);
      2'd2:    leading_zero = (v[15:8] == 8'h00);
      2'd3:    leading_zero = (v[15:12] == 4'h0);
      default: leading_zero = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 16'd1;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    frame_d  = 1'b0;
    commit_c = 1'b0;
    sel_n_d  = 4'b1111;
    seg_n_d  = 7'b1111111;
    nib_c    = 4'h0;

    case (state_q)
      S_OFF: begin
        cnt_d    = 16'd0;
        idx_d    = 2'd0;
        commit_c = pend_q;
        if (ENABLE) state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_GUARD;
          cnt_d   = 16'd0;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_SHOW;
          cnt_d   = 16'd0;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            frame_d  = 1'b1;
            commit_c = pend_q;
          end
        end
      end
      default: state_d = S_OFF;
    endcase

    // Disabling wins over a frame end; a pending value then commits from OFF.
    if (!ENABLE) begin
      state_d = S_OFF;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
      frame_d = 1'b0;
      if (state_q != S_OFF) commit_c = 1'b0;
    end

    if (commit_c) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    if (LOAD) begin
      shadow_d = DATA_IN;
      pend_d   = 1'b1;
    end

    // Outputs are derived from next state so they change together with it.
    if (state_d == S_SHOW) begin
      sel_n_d = ~(4'b0001 << idx_d);
      nib_c   = disp_d[{idx_d, 2'b00} +: 4];
      if (BLANK_EN && leading_zero(disp_d, idx_d)) seg_n_d = 7'b1111111;
      else                                         seg_n_d = glyph(nib_c);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_OFF;
      idx_q    <= 2'd0;
      cnt_q    <= 16'd0;
      disp_q   <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
      sel_n_q  <= 4'b1111;
      seg_n_q  <= 7'b1111111;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ack_q    <= commit_c;
      frame_q  <= frame_d;
      sel_n_q  <= sel_n_d;
      seg_n_q  <= seg_n_d;
    end
  end

  assign ack_d       = commit_c;
  assign LOAD_ACK    = ack_q;
  assign PENDING     = pend_q;
  assign FRAME_DONE  = frame_q;
  assign DIGIT_SEL_N = sel_n_q;
  assign SEG_N       = seg_n_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: frame-position model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_hex_display_scanner;
  localparam int DIV = 4;
  localparam int GRD = 2;
  localparam int P   = DIV + GRD;
  localparam int FR  = 4 * P;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, BLANK_EN, LOAD;
  logic [15:0] DATA_IN;
  logic        LOAD_ACK, PENDING, FRAME_DONE;
  logic [3:0]  DIGIT_SEL_N;
  logic [6:0]  SEG_N;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  bit chk_en = 1'b0;

  hex_display_scanner #(.DIV_COUNT(DIV), .GUARD_CYCLES(GRD)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .BLANK_EN(BLANK_EN),
    .LOAD(LOAD), .DATA_IN(DATA_IN), .LOAD_ACK(LOAD_ACK), .PENDING(PENDING),
    .FRAME_DONE(FRAME_DONE), .DIGIT_SEL_N(DIGIT_SEL_N), .SEG_N(SEG_N)
  );

  always #5 CLK = ~CLK;

  // Lit-segment patterns, A..G on bits 6..0, active low.
  logic [6:0] glyph_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    bit          on;
    int          t;
    logic [15:0] disp;
    logic [15:0] shadow;
    logic        pend;
    logic        ack;
    logic        fd;
    logic        blank;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input logic rst, input logic en,
                                        input logic ld, input logic [15:0] din, input logic bl);
    model_t n;
    logic   commit;
    n = s;
    n.blank = bl;
    if (rst) begin
      n.on = 0; n.t = 0; n.disp = 16'h0; n.shadow = 16'h0;
      n.pend = 0; n.ack = 0; n.fd = 0;
      return n;
    end
    commit = 0;
    n.fd = 0;
    if (!s.on) begin
      commit = s.pend;
      if (en) begin n.on = 1; n.t = 0; end
    end else if (!en) begin
      n.on = 0;
    end else begin
      n.t = s.t + 1;
      if (n.t == FR) begin n.t = 0; n.fd = 1; commit = s.pend; end
    end
    if (commit) begin n.disp = s.shadow; n.pend = 0; end
    n.ack = commit;
    if (ld) begin n.shadow = din; n.pend = 1; end
    return n;
  endfunction

  function automatic logic [3:0] exp_sel(input model_t s);
    if (s.on && (s.t % P) < DIV) return ~(4'b0001 << (s.t / P));
    return 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg(input model_t s);
    int d;
    if (!(s.on && (s.t % P) < DIV)) return 7'b1111111;
    d = s.t / P;
    if (s.blank && d > 0 && (s.disp >> (4 * d)) == 16'h0) return 7'b1111111;
    return glyph_tbl[(s.disp >> (4 * d)) & 16'hF];
  endfunction

  always @(posedge CLK) begin
    m <= model_step(m, RESET, ENABLE, LOAD, DATA_IN, BLANK_EN);
    if (RESET) chk_en <= 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (LOAD_ACK) ack_cnt++;
    if (chk_en) begin
      check("model_sel",   16'(DIGIT_SEL_N), 16'(exp_sel(m)));
      check("model_seg",   16'(SEG_N),       16'(exp_seg(m)));
      check("model_pend",  16'(PENDING),     16'(m.pend));
      check("model_ack",   16'(LOAD_ACK),    16'(m.ack));
      check("model_frame", 16'(FRAME_DONE),  16'(m.fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  logic [3:0] seq [24] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                           4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
                           4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
                           4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
  int base;

  initial begin
    RESET = 1; ENABLE = 1; BLANK_EN = 0; LOAD = 0; DATA_IN = 16'h0;
    cyc(2);
    check("rst_sel", 16'(DIGIT_SEL_N), 16'hF);
    check("rst_seg", 16'(SEG_N), 16'h7F);
    check("rst_pend", 16'(PENDING), 16'h0);
    check("rst_frame", 16'(FRAME_DONE), 16'h0);

    // Free-running scan of an all-zero display.
    RESET = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      check("scan_sel", 16'(DIGIT_SEL_N), 16'(seq[k]));
      if (seq[k] != 4'hF) check("scan_seg", 16'(SEG_N), 16'h01);
    end
    cyc(1);
    check("scan_frame", 16'(FRAME_DONE), 16'h1);
    check("scan_wrap_sel", 16'(DIGIT_SEL_N), 16'hE);

    // Mid-frame load of 1A2F.
    LOAD = 1; DATA_IN = 16'h1A2F; cyc(1); LOAD = 0;
    check("ld_pend", 16'(PENDING), 16'h1);
    cyc(22);
    check("ld_pend_end", 16'(PENDING), 16'h1);
    check("ld_noack", 16'(LOAD_ACK), 16'h0);
    cyc(1);
    check("ld_ack", 16'(LOAD_ACK), 16'h1);
    check("ld_frame", 16'(FRAME_DONE), 16'h1);
    check("ld_d0", 16'(SEG_N), 16'h38);
    cyc(6); check("ld_d1", 16'(SEG_N), 16'h12);
    cyc(6); check("ld_d2", 16'(SEG_N), 16'h08);
    cyc(6); check("ld_d3", 16'(SEG_N), 16'h4F);

    // Leading-zero blanking with 0030, then 0000.
    BLANK_EN = 1; LOAD = 1; DATA_IN = 16'h0030; cyc(1); LOAD = 0;
    cyc(5);
    check("bl_d0", 16'(SEG_N), 16'h01);
    cyc(6);
    check("bl_d1_sel", 16'(DIGIT_SEL_N), 16'hD);
    check("bl_d1", 16'(SEG_N), 16'h06);
    cyc(6);
    check("bl_d2_sel", 16'(DIGIT_SEL_N), 16'hB);
    check("bl_d2", 16'(SEG_N), 16'h7F);
    cyc(6);
    check("bl_d3_sel", 16'(DIGIT_SEL_N), 16'h7);
    check("bl_d3", 16'(SEG_N), 16'h7F);
    LOAD = 1; DATA_IN = 16'h0000; cyc(1); LOAD = 0;
    cyc(5);
    check("bz_d0", 16'(SEG_N), 16'h01);
    cyc(6);
    check("bz_d1_sel", 16'(DIGIT_SEL_N), 16'hD);
    check("bz_d1", 16'(SEG_N), 16'h7F);
    cyc(6);
    check("bz_d2", 16'(SEG_N), 16'h7F);
    BLANK_EN = 0;
    cyc(6);

    // Two loads in one frame, then a load on the commit cycle.
    base = ack_cnt;
    LOAD = 1; DATA_IN = 16'h1111; cyc(1);
    DATA_IN = 16'h2222; cyc(1); LOAD = 0;
    cyc(3);
    LOAD = 1; DATA_IN = 16'h3333; cyc(1); LOAD = 0;
    check("ow_ack", 16'(LOAD_ACK), 16'h1);
    check("ow_pend", 16'(PENDING), 16'h1);
    check("ow_d0", 16'(SEG_N), 16'h12);
    check("ow_acks", 16'(ack_cnt - base), 16'h1);
    cyc(23);
    check("ow_pend_hold", 16'(PENDING), 16'h1);
    check("ow_acks_hold", 16'(ack_cnt - base), 16'h1);
    cyc(1);
    check("ow2_ack", 16'(LOAD_ACK), 16'h1);
    check("ow2_d0", 16'(SEG_N), 16'h06);
    check("ow2_pend", 16'(PENDING), 16'h0);
    check("ow2_acks", 16'(ack_cnt - base), 16'h2);

    // Disable during digit 2 with a value pending.
    LOAD = 1; DATA_IN = 16'h4567; cyc(1); LOAD = 0;
    cyc(11);
    check("dis_sel2", 16'(DIGIT_SEL_N), 16'hB);
    ENABLE = 0; cyc(1);
    check("dis_sel", 16'(DIGIT_SEL_N), 16'hF);
    check("dis_seg", 16'(SEG_N), 16'h7F);
    check("dis_pend", 16'(PENDING), 16'h1);
    cyc(1);
    check("dis_ack", 16'(LOAD_ACK), 16'h1);
    check("dis_pend_clr", 16'(PENDING), 16'h0);
    cyc(2);
    ENABLE = 1; cyc(1);
    check("ren_sel", 16'(DIGIT_SEL_N), 16'hE);
    check("ren_seg", 16'(SEG_N), 16'h0F);

    // Reset during GUARD with a value pending; coincident LOAD discarded.
    cyc(4);
    LOAD = 1; DATA_IN = 16'h89AB; cyc(1); LOAD = 0;
    check("rg_pend", 16'(PENDING), 16'h1);
    RESET = 1; LOAD = 1; DATA_IN = 16'hFFFF; cyc(1); LOAD = 0;
    check("rg_sel", 16'(DIGIT_SEL_N), 16'hF);
    check("rg_seg", 16'(SEG_N), 16'h7F);
    check("rg_pend0", 16'(PENDING), 16'h0);
    check("rg_ack", 16'(LOAD_ACK), 16'h0);
    cyc(1);
    RESET = 0; cyc(1);
    check("rr_sel", 16'(DIGIT_SEL_N), 16'hE);
    check("rr_seg", 16'(SEG_N), 16'h01);
    check("rr_pend", 16'(PENDING), 16'h0);
    check("rr_ack", 16'(LOAD_ACK), 16'h0);

    cyc(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
